twiddle_gen: RTL and testbench
==============================

TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 Parameter N, default 36: FFT length; SHALL be a multiple of 4 and of R.
REQ-002 Parameter R, default 6: radix; inner length L = N/R.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a twiddle sequence.
REQ-006 busy  output  1  high from the cycle after an accepted start until the last word is accepted.
REQ-007 w_re  output  32  IEEE-754 single, cos(2*pi*e/N).
REQ-008 w_img  output  32  IEEE-754 single, -sin(2*pi*e/N).
REQ-009 w_valid  output  1  w_re/w_img/w_exp/w_last are valid.
REQ-010 w_ready  input  1  the downstream complex multiplier accepts the word this cycle.
REQ-011 w_last  output  1  marks the N-th word of a sequence.
REQ-012 w_exp  output  ceil(log2 N)  exponent e of the current word, for debug.

Function
REQ-013 The block SHALL emit N words per sequence, ordered n1 = 0..R-1 (outer) and n2 = 0..L-1 (inner), with e = (n1*n2) mod N.
REQ-014 e SHALL be produced by modular accumulation: e is cleared at each n2 = 0 and incremented by n1 mod N per step, with no multiplier.
REQ-015 A constant table T[j] = cos(2*pi*j/N), j = 0..N/4, SHALL be held as 32-bit float words, with Q = N/4.
REQ-016 With q = e div Q and m = e mod Q: q0 gives cos=T[m], sin=T[Q-m]; q1 gives cos=-T[Q-m], sin=T[m]; q2 gives cos=-T[m], sin=-T[Q-m]; q3 gives cos=T[Q-m], sin=-T[m].
REQ-017 Negation SHALL invert bit 31 only; a result whose bits 30:0 are zero SHALL be output with bit 31 = 0 (never 0x80000000).
REQ-018 States SHALL be IDLE, RUN and LAST.
REQ-019 In IDLE, start SHALL move the block to RUN. In RUN, the state SHALL become LAST when the word with w_last loads. In LAST, the state SHALL return to IDLE when that word is accepted (w_valid && w_ready).
REQ-020 Words SHALL pass through one output register, and the first word SHALL be valid the cycle after start.
REQ-021 The output register SHALL load a new word when !w_valid || w_ready, and otherwise hold all outputs stable.
REQ-022 With w_ready held high, a sequence SHALL take exactly N consecutive valid cycles, and busy SHALL drop the cycle after the last accept.
REQ-023 start while busy SHALL be ignored, with no restart or corruption.
REQ-024 start in the same cycle as the final accept SHALL be ignored; a new start SHALL be given no earlier than the cycle after busy falls.
REQ-025 w_last SHALL be high only together with w_valid, on the word n1 = R-1, n2 = L-1.

Reset
REQ-026 Reset SHALL force: state IDLE, busy=0, w_valid=0, w_last=0, w_re=0, w_img=0, w_exp=0, and all counters 0.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence at the next edge with no further valid words.
REQ-028 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 With macro TWIDDLE_CONJ_EN defined, the block SHALL add input port inv (1 bit), sampled on an accepted start.
REQ-030 When inv=1, w_img SHALL equal +sin(2*pi*e/N) for the whole sequence (IFFT twiddles), with REQ-017 still applied.
REQ-031 Without TWIDDLE_CONJ_EN, port inv SHALL NOT exist and w_img SHALL always equal -sin.

Verification (N=36, R=6)
REQ-032 Reset, then start, with w_ready=1 -> first word valid next cycle: e=0, w_re=0x3F800000, w_img=0x00000000; 36 valid cycles; w_last on the 36th; busy low after.
REQ-033 Full sequence -> w_exp equals (n1*n2) mod 36 for each word. Spot checks: e=6 gives w_re=0x3F000000, w_img=0xBF5DB3D7; e=9 gives w_re=0x00000000, w_img=0xBF800000; e=18 gives w_re=0xBF800000, w_img=0x00000000.
REQ-034 Toggle w_ready pseudo-randomly -> outputs stable while w_valid && !w_ready; exactly 36 accepts; order identical to REQ-033.
REQ-035 Start pulses at word 10 plus rst at word 20 -> the start is ignored; after rst, w_valid=0 and busy=0 on the next edge; a fresh start restarts at e=0.
REQ-036 With TWIDDLE_CONJ_EN defined, inv=1 and e=9 -> w_img=0x3F800000; no output word is ever 0x80000000.

Source files
------------

// File: rtl/twiddle_gen.sv
// ============================================================================
// Module   : twiddle_gen
// Purpose  : Streams FFT twiddle factors (cos, -sin) for an N = R x L index map.
// Options  : TWIDDLE_CONJ_EN adds port inv, which selects +sin (IFFT twiddles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twiddle_gen #(
  parameter int N = 36,
  parameter int R = 6,
  localparam int EW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef TWIDDLE_CONJ_EN
  input  logic          inv,
`endif
  input  logic          start,
  output logic          busy,
  output logic [31:0]   w_re,
  output logic [31:0]   w_img,
  output logic          w_valid,
  input  logic          w_ready,
  output logic          w_last,
  output logic [EW-1:0] w_exp
);

  localparam int L   = N / R;
  localparam int Q   = N / 4;
  localparam int N1W = (R > 1) ? $clog2(R) : 1;
  localparam int N2W = (L > 1) ? $clog2(L) : 1;

  localparam logic [EW-1:0]  c_Q1 = EW'(Q);
  localparam logic [EW-1:0]  c_Q2 = EW'(2 * Q);
  localparam logic [EW-1:0]  c_Q3 = EW'(3 * Q);
  localparam logic [N1W-1:0] c_N1_MAX = N1W'(R - 1);
  localparam logic [N2W-1:0] c_N2_MAX = N2W'(L - 1);
  localparam logic [EW:0]    c_NW = (EW + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N1W-1:0] r_n1;
  logic [N2W-1:0] r_n2;
  logic [EW-1:0]  r_e;
  logic [31:0]    r_re;
  logic [31:0]    r_img;
  logic           r_valid;
  logic           r_last;
  logic [EW-1:0]  r_exp;

  logic           w_start_acc;
  logic           w_gen;
  logic           w_src_last;
  logic           w_inv;
  logic [EW:0]    w_e_sum;
  logic [1:0]     w_q;
  logic [EW-1:0]  w_m;
  logic [31:0]    w_tm;
  logic [31:0]    w_tqm;
  logic [31:0]    w_cos_v;
  logic [31:0]    w_sin_v;
  logic           w_cos_n;
  logic           w_sin_n;

  // Quarter-wave cosine table, values tabulated for N = 36 (10 degree steps).
  function automatic logic [31:0] tab(input logic [EW-1:0] j);
    case (int'(j))
      0:       return 32'h3F800000;
      1:       return 32'h3F7C1C5C;
      2:       return 32'h3F708FB2;
      3:       return 32'h3F5DB3D7;
      4:       return 32'h3F441B7D;
      5:       return 32'h3F248DBB;
      6:       return 32'h3F000000;
      7:       return 32'h3EAF1D44;
      8:       return 32'h3E31D0D4;
      default: return 32'h00000000;
    endcase
  endfunction

  // Sign flip that never produces negative zero.
  function automatic logic [31:0] fneg(input logic [31:0] x, input logic n);
    if (x[30:0] == 31'd0) return 32'd0;
    return {x[31] ^ n, x[30:0]};
  endfunction

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_gen       = w_start_acc || ((r_state == S_RUN) && (!r_valid || w_ready));
  assign w_src_last  = (r_n1 == c_N1_MAX) && (r_n2 == c_N2_MAX);
  assign w_e_sum     = {1'b0, r_e} + (EW + 1)'(r_n1);

`ifdef TWIDDLE_CONJ_EN
  logic r_inv;
  always_ff @(posedge clk) begin
    if (rst)              r_inv <= 1'b0;
    else if (w_start_acc) r_inv <= inv;
  end
  assign w_inv = w_start_acc ? inv : r_inv;
`else
  assign w_inv = 1'b0;
`endif

  always_comb begin
    w_q = 2'd0;
    w_m = r_e;
    if (r_e >= c_Q3) begin
      w_q = 2'd3;
      w_m = r_e - c_Q3;
    end else if (r_e >= c_Q2) begin
      w_q = 2'd2;
      w_m = r_e - c_Q2;
    end else if (r_e >= c_Q1) begin
      w_q = 2'd1;
      w_m = r_e - c_Q1;
    end
    w_tm  = tab(w_m);
    w_tqm = tab(c_Q1 - w_m);
    case (w_q)
      2'd0:    begin w_cos_v = w_tm;  w_cos_n = 1'b0; w_sin_v = w_tqm; w_sin_n = 1'b0; end
      2'd1:    begin w_cos_v = w_tqm; w_cos_n = 1'b1; w_sin_v = w_tm;  w_sin_n = 1'b0; end
      2'd2:    begin w_cos_v = w_tm;  w_cos_n = 1'b1; w_sin_v = w_tqm; w_sin_n = 1'b1; end
      default: begin w_cos_v = w_tqm; w_cos_n = 1'b0; w_sin_v = w_tm;  w_sin_n = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_gen && w_src_last) w_state_nxt = S_LAST;
      S_LAST:  if (r_valid && w_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n1    <= '0;
      r_n2    <= '0;
      r_e     <= '0;
      r_re    <= '0;
      r_img   <= '0;
      r_exp   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_gen) begin
      r_re    <= fneg(w_cos_v, w_cos_n);
      r_img   <= fneg(w_sin_v, w_sin_n ^ ~w_inv);
      r_exp   <= r_e;
      r_valid <= 1'b1;
      r_last  <= w_src_last;
      // e accumulates n1 per inner step and restarts at each new row.
      if (w_src_last) begin
        r_n1 <= '0;
        r_n2 <= '0;
        r_e  <= '0;
      end else if (r_n2 == c_N2_MAX) begin
        r_n1 <= r_n1 + 1'b1;
        r_n2 <= '0;
        r_e  <= '0;
      end else begin
        r_n2 <= r_n2 + 1'b1;
        r_e  <= (w_e_sum >= c_NW) ? EW'(w_e_sum - c_NW) : EW'(w_e_sum);
      end
    end else if (r_valid && w_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign w_re    = r_re;
  assign w_img   = r_img;
  assign w_valid = r_valid;
  assign w_last  = r_last;
  assign w_exp   = r_exp;

endmodule

`default_nettype wire

// File: tb/tb_twiddle_gen.sv
// ============================================================================
// Module   : tb_twiddle_gen
// Purpose  : Directed self-checking bench for twiddle_gen (N = 36, R = 6).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twiddle_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        w_ready;
  logic        busy;
  logic [31:0] w_re;
  logic [31:0] w_img;
  logic        w_valid;
  logic        w_last;
  logic [5:0]  w_exp;
`ifdef TWIDDLE_CONJ_EN
  logic        inv;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  twiddle_gen #(.N(36), .R(6)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef TWIDDLE_CONJ_EN
    .inv     (inv),
`endif
    .start   (start),
    .busy    (busy),
    .w_re    (w_re),
    .w_img   (w_img),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_last  (w_last),
    .w_exp   (w_exp)
  );

  // cos(10 degrees * k), k = 0..35, as single-precision words.
  localparam logic [31:0] C_TAB [0:35] = '{
    32'h3F800000, 32'h3F7C1C5C, 32'h3F708FB2, 32'h3F5DB3D7, 32'h3F441B7D, 32'h3F248DBB,
    32'h3F000000, 32'h3EAF1D44, 32'h3E31D0D4, 32'h00000000, 32'hBE31D0D4, 32'hBEAF1D44,
    32'hBF000000, 32'hBF248DBB, 32'hBF441B7D, 32'hBF5DB3D7, 32'hBF708FB2, 32'hBF7C1C5C,
    32'hBF800000, 32'hBF7C1C5C, 32'hBF708FB2, 32'hBF5DB3D7, 32'hBF441B7D, 32'hBF248DBB,
    32'hBF000000, 32'hBEAF1D44, 32'hBE31D0D4, 32'h00000000, 32'h3E31D0D4, 32'h3EAF1D44,
    32'h3F000000, 32'h3F248DBB, 32'h3F441B7D, 32'h3F5DB3D7, 32'h3F708FB2, 32'h3F7C1C5C
  };

  logic [71:0] obs;
  assign obs = {w_valid, w_last, w_exp, w_re, w_img};

  // Expected {valid, last, e, re, img} for word idx; -sin(x) = cos(x + 90), +sin(x) = cos(x - 90).
  function automatic logic [71:0] exp_word(input int idx, input bit conj);
    int e;
    int k;
    e = ((idx / 6) * (idx % 6)) % 36;
    k = conj ? (e + 27) % 36 : (e + 9) % 36;
    return {1'b1, (idx == 35), 6'(e), C_TAB[e], C_TAB[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    n_total++;
    if ({busy, obs} !== 73'd0) $display("FAIL reset_with_start: got busy=%b %h expected all zero", busy, obs);
    else n_pass++;
    rst = 1'b0;
    start = 1'b0;
    tick();
    n_total++;
    if ({busy, obs} !== 73'd0) $display("FAIL reset_release: got busy=%b %h expected all zero", busy, obs);
    else n_pass++;
  endtask

  task automatic test_full_seq();
    w_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL full_busy: got %b expected 1", busy);
    else n_pass++;
    for (int i = 0; i < 36; i++) begin
      n_total++;
      if (obs !== exp_word(i, 1'b0)) $display("FAIL full_word%0d: got %h expected %h", i, obs, exp_word(i, 1'b0));
      else n_pass++;
      tick();
    end
    n_total++;
    if ({busy, w_valid, w_last} !== 3'b000) $display("FAIL full_end: got busy/valid/last=%b%b%b expected 000", busy, w_valid, w_last);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int cyc = 0;
    bit held;
    bit took;
    logic [71:0] snap;
    start = 1'b1;
    w_ready = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    while (acc < 36 && cyc < 500) begin
      if (w_valid) begin
        n_total++;
        if (obs !== exp_word(acc, 1'b0)) $display("FAIL bp_word%0d: got %h expected %h", acc, obs, exp_word(acc, 1'b0));
        else n_pass++;
      end
      w_ready = 1'($urandom_range(0, 1));
      held = w_valid && !w_ready;
      took = w_valid && w_ready;
      snap = obs;
      tick();
      cyc++;
      if (took) acc++;
      if (held) begin
        n_total++;
        if (obs !== snap) $display("FAIL bp_hold: got %h expected %h", obs, snap);
        else n_pass++;
      end
    end
    n_total++;
    if (acc != 36) $display("FAIL bp_accepts: got %0d expected 36", acc);
    else n_pass++;
    n_total++;
    if ({busy, w_valid} !== 2'b00) $display("FAIL bp_end: got busy/valid=%b%b expected 00", busy, w_valid);
    else n_pass++;
    w_ready = 1'b1;
  endtask

  task automatic test_start_and_reset();
    int cnt = 0;
    int cyc = 0;
    w_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (i == 11 || i == 20) begin
        n_total++;
        if (obs !== exp_word(i, 1'b0)) $display("FAIL busy_start_word%0d: got %h expected %h", i, obs, exp_word(i, 1'b0));
        else n_pass++;
      end
      if (i == 10) start = 1'b1;
      if (i == 20) rst = 1'b1;
      tick();
      start = 1'b0;
    end
    rst = 1'b0;
    n_total++;
    if ({busy, w_valid} !== 2'b00) $display("FAIL midreset: got busy/valid=%b%b expected 00", busy, w_valid);
    else n_pass++;
    tick();
    n_total++;
    if (w_valid !== 1'b0) $display("FAIL midreset_hold: got valid=%b expected 0", w_valid);
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (obs !== exp_word(0, 1'b0)) $display("FAIL restart_word0: got %h expected %h", obs, exp_word(0, 1'b0));
    else n_pass++;
    while (busy && cyc < 100) begin
      if (w_valid) cnt++;
      tick();
      cyc++;
    end
    n_total++;
    if (cnt != 36) $display("FAIL restart_count: got %0d expected 36", cnt);
    else n_pass++;
  endtask

  task automatic test_start_on_final();
    w_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 35; i++) tick();
    n_total++;
    if ({w_valid, w_last} !== 2'b11) $display("FAIL final_last: got valid/last=%b%b expected 11", w_valid, w_last);
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({busy, w_valid} !== 2'b00) $display("FAIL final_start: got busy/valid=%b%b expected 00", busy, w_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({busy, w_valid} !== 2'b00) $display("FAIL final_start_hold: got busy/valid=%b%b expected 00", busy, w_valid);
    else n_pass++;
  endtask

`ifdef TWIDDLE_CONJ_EN
  task automatic test_conj();
    w_ready = 1'b1;
    inv = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    inv = 1'b0;
    for (int i = 0; i < 36; i++) begin
      n_total++;
      if (obs !== exp_word(i, 1'b1)) $display("FAIL conj_word%0d: got %h expected %h", i, obs, exp_word(i, 1'b1));
      else n_pass++;
      n_total++;
      if (w_re === 32'h80000000 || w_img === 32'h80000000) $display("FAIL conj_negzero%0d: got %h/%h expected no 80000000", i, w_re, w_img);
      else n_pass++;
      tick();
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    w_ready = 1'b1;
`ifdef TWIDDLE_CONJ_EN
    inv = 1'b0;
`endif
    test_reset();
    test_full_seq();
    test_backpressure();
    test_start_and_reset();
    test_start_on_final();
`ifdef TWIDDLE_CONJ_EN
    test_conj();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
